button_pulse_conditioner: RTL and testbench

//  Conditions a raw, asynchronous, bouncing push-button into a clean one-cycle pulse.

---
 rtl/button_pulse_conditioner_if.sv | 44 ++++
 rtl/button_pulse_conditioner.sv | 228 ++++++++++++++++++++++
 tb/tb_button_pulse_conditioner.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/button_pulse_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_pulse_conditioner_if
//   Signal bundle between a push-button source and the pulse conditioner.
//   Clock and reset are not part of the bundle; they stay as plain ports.
//
//   Parameters
//     IDX_W      width of the press index
//
//   Signals
//     btn_in     raw, asynchronous, bouncing button (1 = pressed)
//     idx_clr    synchronous clear of press_idx
//     btn_level  debounced button level
//     btn_pulse  one-cycle strobe per accepted press (feeds memory_loader.result_toggle)
//     press_idx  count of accepted pulses, modulo 2**IDX_W
//
//   Modports
//     master     button/control side: drives btn_in, idx_clr
//     slave      conditioner side: drives btn_level, btn_pulse, press_idx
// -----------------------------------------------------------------------------
interface button_pulse_conditioner_if #(
    parameter int IDX_W = 4
);
    logic             btn_in;
    logic             idx_clr;
    logic             btn_level;
    logic             btn_pulse;
    logic [IDX_W-1:0] press_idx;

    modport master (
        output btn_in,
        output idx_clr,
        input  btn_level,
        input  btn_pulse,
        input  press_idx
    );

    modport slave (
        input  btn_in,
        input  idx_clr,
        output btn_level,
        output btn_pulse,
        output press_idx
    );
endinterface

// File: rtl/button_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// button_pulse_conditioner
//   Turns a raw, bouncing push-button into a clean one-cycle pulse that steps
//   the downstream result display once per accepted press, plus a wrap-around
//   press index mirroring which result is currently shown.
//
//   Path: btn_in -> 2-FF synchroniser -> debounce FSM -> registered outputs.
//   A press (or release) is accepted only after the synchronised level has
//   been stable for DEBOUNCE_CYCLES cycles; any shorter glitch is discarded.
//
//   Parameters
//     DEBOUNCE_CYCLES  stable cycles needed to accept a press or a release
//     CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//     IDX_W            press_idx width
//     REPEAT_CYCLES    auto-repeat period while held (HOLD_REPEAT_EN only)
//
//   Ports
//     clk   system clock
//     rst   synchronous, active-low reset
//     bus   slave side of button_pulse_conditioner_if
//             (btn_in, idx_clr in; btn_level, btn_pulse, press_idx out)
//
//   Build option
//     HOLD_REPEAT_EN  when defined, holding the button emits one extra pulse
//                     every REPEAT_CYCLES cycles while in HELD. When undefined
//                     there is exactly one pulse per press and no repeat
//                     counter exists.
// -----------------------------------------------------------------------------
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 20,
    parameter int IDX_W           = 4,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    button_pulse_conditioner_if.slave     bus
);

    // Elaboration-time parameter sanity checks.
    if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_cnt_w_check
        $error("CNT_W too small for DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 2) begin : g_repeat_check
        $error("REPEAT_CYCLES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    localparam int SYNC_STAGES = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONF_PRESS = 2'd1,
        HELD       = 2'd2,
        CONF_REL   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Synchroniser: stage 0 is s1, stage 1 is s2. Only s2 reaches the FSM.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s2;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= bus.btn_in;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign s2 = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic             level_reg,  level_next;
    logic             pulse_reg,  pulse_next;
    logic [IDX_W-1:0] idx_reg,    idx_next;

    logic             press_accept;
    logic             release_accept;
    logic             rpt_fire;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            pulse_reg <= 1'b0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            pulse_reg <= pulse_next;
            idx_reg   <= idx_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. The debounce counter restarts from 0 whenever the
    // synchronised level disagrees with the level being confirmed, so only an
    // uninterrupted run of DEBOUNCE_CYCLES samples is accepted.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        press_accept   = 1'b0;
        release_accept = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s2) begin
                    state_next = CONF_PRESS;
                    cnt_next   = '0;
                end
            end
            CONF_PRESS: begin
                if (!s2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = HELD;
                    cnt_next     = '0;
                    press_accept = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!s2) begin
                    state_next = CONF_REL;
                    cnt_next   = '0;
                end
            end
            CONF_REL: begin
                // A bounce back to 1 returns to HELD without a new pulse.
                if (s2) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next     = IDLE;
                    cnt_next       = '0;
                    release_accept = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef HOLD_REPEAT_EN
    // -------------------------------------------------------------------------
    // Auto-repeat: counts only while the button stays in HELD. It is held at
    // zero everywhere else, which clears it on every entry to HELD and on the
    // way out to CONF_REL.
    // -------------------------------------------------------------------------
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_reg, rpt_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rpt_reg <= '0;
        end else begin
            rpt_reg <= rpt_next;
        end
    end

    always_comb begin
        rpt_next = '0;
        rpt_fire = 1'b0;
        if (state_reg == HELD && s2) begin
            if (rpt_reg == RPT_LAST) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_next = rpt_reg + 1'b1;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Output logic. The pulse defaults low every cycle; an index clear takes
    // priority over a same-cycle increment, but the pulse still goes out.
    // -------------------------------------------------------------------------
    always_comb begin
        level_next = level_reg;
        if (press_accept) begin
            level_next = 1'b1;
        end else if (release_accept) begin
            level_next = 1'b0;
        end

        pulse_next = press_accept | rpt_fire;

        idx_next = idx_reg;
        if (bus.idx_clr) begin
            idx_next = '0;
        end else if (pulse_next) begin
            idx_next = idx_reg + 1'b1;
        end
    end

    assign bus.btn_level = level_reg;
    assign bus.btn_pulse = pulse_reg;
    assign bus.press_idx = idx_reg;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
module tb_button_pulse_conditioner;

    localparam int DEB = 8;
    localparam int RPT = 32;
    localparam int IW  = 4;

    logic clk;
    logic rst;

    button_pulse_conditioner_if #(.IDX_W(IW)) bif ();

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (20),
        .IDX_W           (IW),
        .REPEAT_CYCLES   (RPT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter and pulse / level monitors, updated 1 time unit after
    // each posedge so the directed sequence reads settled values at negedge.
    int cyc        = 0;
    int pulse_cnt  = 0;
    int last_pulse = -1;
    int level_hi   = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bif.btn_pulse === 1'b1) begin
            pulse_cnt  = pulse_cnt + 1;
            last_pulse = cyc;
        end
        if (bif.btn_level === 1'b1) level_hi = level_hi + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic nwait(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Clean press: held for 'hold' cycles, then released long enough for the
    // release to be confirmed and the FSM to be back in IDLE.
    task automatic press(input int hold);
        bif.btn_in = 1'b1;
        nwait(hold);
        bif.btn_in = 1'b0;
        nwait(DEB + 5);
    endtask

    task automatic clear_idx();
        bif.idx_clr = 1'b1;
        nwait(1);
        bif.idx_clr = 1'b0;
    endtask

    int e;
    int p0;
    int l0;

    initial begin
        rst         = 1'b0;
        bif.btn_in  = 1'b0;
        bif.idx_clr = 1'b0;
        nwait(4);

        // ---- reset state ----
        chk("reset_level", 32'(bif.btn_level), 0);
        chk("reset_pulse", 32'(bif.btn_pulse), 0);
        chk("reset_idx",   32'(bif.press_idx), 0);
        rst = 1'b1;
        nwait(3);
        $display("reset released at cycle %0d", cyc);

        // ---- 1: clean press, 40 cycles ----
        p0 = pulse_cnt;
        bif.btn_in = 1'b1;
        e = cyc + 1;
        nwait(10);                               // after E+9
        chk("press_level_early", 32'(bif.btn_level), 0);
        chk("press_pulse_early", 32'(bif.btn_pulse), 0);
        nwait(1);                                // after E+10
        chk("press_level", 32'(bif.btn_level), 1);
        chk("press_pulse", 32'(bif.btn_pulse), 1);
        chk("press_idx",   32'(bif.press_idx), 1);
        chk("press_pulse_edge", last_pulse, e + 10);
        nwait(1);
        chk("press_pulse_one_cycle", 32'(bif.btn_pulse), 0);
        nwait(28);                               // 40 cycles high in total
        bif.btn_in = 1'b0;
        nwait(10);                               // after R+9
        chk("release_level_early", 32'(bif.btn_level), 1);
        nwait(1);                                // after R+10
        chk("release_level", 32'(bif.btn_level), 0);
        chk("press_pulse_count", pulse_cnt - p0, 1);
        $display("clean press: pulse at edge %0d, idx=%0d", last_pulse, bif.press_idx);
        nwait(3);

        // ---- 2: bounce ----
        clear_idx();
        chk("bounce_idx_cleared", 32'(bif.press_idx), 0);
        p0 = pulse_cnt;
        l0 = level_hi;
        for (int g = 0; g < 5; g++) begin
            bif.btn_in = 1'b1;
            nwait(3);
            bif.btn_in = 1'b0;
            nwait(3);
        end
        nwait(DEB + 5);
        chk("bounce_pulses", pulse_cnt - p0, 0);
        chk("bounce_level_hi", level_hi - l0, 0);
        chk("bounce_level", 32'(bif.btn_level), 0);
        chk("bounce_idx", 32'(bif.press_idx), 0);
        $display("bounce: 5 glitches, pulses=%0d", pulse_cnt - p0);

        // ---- 3: wrap-around, 17 presses ----
        p0 = pulse_cnt;
        for (int k = 1; k <= 17; k++) begin
            press(12);
            chk($sformatf("wrap_idx_%0d", k), 32'(bif.press_idx), k % 16);
            $display("wrap press %0d: idx=%0d", k, bif.press_idx);
        end
        chk("wrap_pulses", pulse_cnt - p0, 17);

        // ---- 4: clear coincides with increment 5->6 ----
        clear_idx();
        for (int k = 0; k < 5; k++) press(12);
        chk("simul_pre_idx", 32'(bif.press_idx), 5);
        p0 = pulse_cnt;
        bif.btn_in = 1'b1;
        nwait(10);                               // after E+9, increment at E+10
        bif.idx_clr = 1'b1;
        nwait(1);
        bif.idx_clr = 1'b0;
        chk("simul_pulse", 32'(bif.btn_pulse), 1);
        chk("simul_idx", 32'(bif.press_idx), 0);
        nwait(10);
        bif.btn_in = 1'b0;
        nwait(DEB + 5);
        chk("simul_pulse_count", pulse_cnt - p0, 1);
        chk("simul_idx_after", 32'(bif.press_idx), 0);
        $display("simultaneous clear: idx=%0d pulses=%0d", bif.press_idx, pulse_cnt - p0);

        // ---- 5: reset during CONF_PRESS with button held ----
        press(12);                               // idx becomes 1
        p0 = pulse_cnt;
        bif.btn_in = 1'b1;
        nwait(7);                                // after E+6: cnt==4
        rst = 1'b0;
        nwait(3);
        chk("rst_mid_level", 32'(bif.btn_level), 0);
        chk("rst_mid_pulse", 32'(bif.btn_pulse), 0);
        chk("rst_mid_idx",   32'(bif.press_idx), 0);
        chk("rst_mid_no_pulse", pulse_cnt - p0, 0);
        rst = 1'b1;
        e = cyc + 1;                             // first sampling edge after reset
        nwait(10);
        chk("rst_rel_pulse_early", 32'(bif.btn_pulse), 0);
        nwait(1);
        chk("rst_rel_pulse", 32'(bif.btn_pulse), 1);
        chk("rst_rel_level", 32'(bif.btn_level), 1);
        chk("rst_rel_pulse_edge", last_pulse, e + 10);
        chk("rst_rel_idx", 32'(bif.press_idx), 1);
        bif.btn_in = 1'b0;
        nwait(DEB + 5);
        $display("reset mid-press: pulse at edge %0d, idx=%0d", last_pulse, bif.press_idx);

        // ---- 6: long hold, 100 cycles ----
        clear_idx();
        p0 = pulse_cnt;
        bif.btn_in = 1'b1;
        e = cyc + 1;
        nwait(100);
        bif.btn_in = 1'b0;
        nwait(DEB + 6);
`ifdef HOLD_REPEAT_EN
        chk("hold_pulses", pulse_cnt - p0, 3);
        chk("hold_idx", 32'(bif.press_idx), 3);
        chk("hold_last_pulse_edge", last_pulse, e + 74);
`else
        chk("hold_pulses", pulse_cnt - p0, 1);
        chk("hold_idx", 32'(bif.press_idx), 1);
        chk("hold_last_pulse_edge", last_pulse, e + 10);
`endif
        chk("hold_level_after", 32'(bif.btn_level), 0);
        $display("long hold: pulses=%0d idx=%0d", pulse_cnt - p0, bif.press_idx);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
